fifo_uart_tx: RTL
=================

Name: fifo_uart_tx

Overview:
- Downstream consumer of the 8-byte synchronous FIFO.
- Pops bytes from the FIFO read port one at a time and serialises each as an asynchronous UART frame: start bit, 8 data bits LSB first, optional even parity, one stop bit.
- Sits between the FIFO and the chip's serial TX pad.
- Owns the FIFO read enable; it never reads an empty FIFO.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal range 2..65535.
- PARITY_EN, 0, 1 = append an even-parity bit after the data bits; 0 = no parity bit.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  transmit enable; gates only the start of new frames.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data  input  8  FIFO registered read data; valid the cycle after a read.
- fifo_rd_en  output  1  FIFO read strobe, one-cycle pulse per byte.
- tx  output  1  serial line; idle high.
- busy  output  1  high whenever state != IDLE.
- byte_count  output  8  frames fully transmitted since reset; wraps 255->0.

Behaviour:
- Reset (async, immediate): state=IDLE, tx=1, fifo_rd_en=0, busy=0, byte_count=0, baud counter=0, bit index=0, shift register=0. Applies mid-frame too: frame aborted, line returns high at once, no partial byte counted.
- tx is a registered output; fifo_rd_en and busy are decoded from the state register (Moore).
- IDLE: tx=1. If en=1 and fifo_empty=0 at a rising edge, go to FETCH; otherwise stay.
- FETCH (1 cycle): fifo_rd_en=1. The FIFO updates fifo_data at the edge ending FETCH. Go to LOAD.
- LOAD (1 cycle): fifo_rd_en=0. Capture fifo_data into the 8-bit shift register at the edge ending LOAD. Compute parity = XOR of the byte. Go to START.
- START: tx=0 for exactly CLKS_PER_BIT cycles. The baud counter counts 0..CLKS_PER_BIT-1 and resets on every bit boundary.
- DATA: 8 bit periods, each CLKS_PER_BIT cycles. tx = shift[0]; shift right by 1 at each bit boundary. Bit index runs 0..7; after bit 7 go to PARITY if PARITY_EN=1, else to STOP.
- PARITY: tx = XOR of the byte (even parity) for CLKS_PER_BIT cycles.
- STOP: tx=1 for CLKS_PER_BIT cycles. At the final cycle, byte_count increments by 1 (8-bit wrap) and the state returns to IDLE.
- Frame length: (10 + PARITY_EN) * CLKS_PER_BIT cycles, measured from the first START cycle.
- Minimum gap between frames: 2 cycles of tx=1 (FETCH and LOAD) beyond the stop bit, plus 1 IDLE cycle. Back-to-back throughput is therefore one frame per frame length + 3 cycles.
- en=0 mid-frame: the current frame completes normally; no new FETCH occurs until en=1.
- fifo_empty rising during a frame: no effect on the frame in progress. fifo_empty is sampled only in IDLE.
- fifo_rd_en is never asserted while fifo_empty=1 at the IDLE decision edge, and never for more than 1 cycle per byte.
- The baud counter width is sized for CLKS_PER_BIT-1; no overflow is possible.

Test Plan:
1. CLKS_PER_BIT=4, PARITY_EN=0; FIFO preloaded with 0xA5, en=1 -> fifo_rd_en high exactly 1 cycle, 1 cycle after the IDLE edge. tx sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles total). Then byte_count=1, busy=0.
2. Three bytes 0x00, 0xFF, 0x3C queued, en=1 -> three frames with correct LSB-first bits. Each inter-frame gap is exactly 3 cycles of tx=1 after the stop bit. 3 read pulses total; byte_count=3.
3. PARITY_EN=1, byte 0x07 -> parity bit tx=1. Byte 0x03 -> parity bit tx=0. Frame length 44 cycles at CLKS_PER_BIT=4.
4. en=0 with FIFO non-empty for 50 cycles -> fifo_rd_en stays 0, tx=1. Drop en in mid-frame -> that frame completes and no further read occurs.
5. Assert rst during DATA bit 3 -> tx=1 and busy=0 immediately, with no clock edge needed; byte_count=0. After release with FIFO still non-empty, the next byte is fetched and sent intact.
6. fifo_empty held high, en=1 for 100 cycles -> no fifo_rd_en pulse, tx=1, busy=0. 256 frames sent -> byte_count wraps to 0.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// FIFO-fed UART transmitter: pops one byte per frame and sends a start bit, 8 data bits
// LSB first, an optional even-parity bit and one stop bit on an idle-high line.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy,
  output logic [7:0] byte_count
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, PARITY, STOP} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] baud_cnt, baud_nx;
  logic [2:0]    bit_idx, bit_nx;
  logic [7:0]    shift_reg, shift_nx;
  logic          parity_bit, parity_nx;
  logic          tx_nx;
  logic          bit_end;
  logic          frame_done;

  assign bit_end    = (baud_cnt == BAUD_LAST);
  assign fifo_rd_en = (state == FETCH);
  assign busy       = (state != IDLE);

  always_comb begin
    state_nx   = state;
    baud_nx    = baud_cnt;
    bit_nx     = bit_idx;
    shift_nx   = shift_reg;
    parity_nx  = parity_bit;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        baud_nx = '0;
        if (en && !fifo_empty) state_nx = FETCH;
      end
      FETCH: state_nx = LOAD;
      LOAD: begin
        shift_nx  = fifo_data;
        parity_nx = ^fifo_data;
        baud_nx   = '0;
        bit_nx    = '0;
        state_nx  = START;
      end
      START: begin
        if (!bit_end) baud_nx = baud_cnt + CW'(1);
        else begin
          baud_nx  = '0;
          state_nx = DATA;
        end
      end
      DATA: begin
        if (!bit_end) baud_nx = baud_cnt + CW'(1);
        else begin
          baud_nx  = '0;
          shift_nx = {1'b0, shift_reg[7:1]};
          if (bit_idx == 3'd7) begin
            bit_nx   = '0;
            state_nx = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_nx = bit_idx + 3'd1;
          end
        end
      end
      PARITY: begin
        if (!bit_end) baud_nx = baud_cnt + CW'(1);
        else begin
          baud_nx  = '0;
          state_nx = STOP;
        end
      end
      STOP: begin
        if (!bit_end) baud_nx = baud_cnt + CW'(1);
        else begin
          baud_nx    = '0;
          frame_done = 1'b1;
          state_nx   = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // tx is registered, so it is decoded from the state the FSM is about to enter
  always_comb begin
    tx_nx = 1'b1;
    case (state_nx)
      START:   tx_nx = 1'b0;
      DATA:    tx_nx = shift_nx[0];
      PARITY:  tx_nx = parity_nx;
      default: tx_nx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      tx         <= 1'b1;
      byte_count <= '0;
    end else begin
      state      <= state_nx;
      baud_cnt   <= baud_nx;
      bit_idx    <= bit_nx;
      shift_reg  <= shift_nx;
      parity_bit <= parity_nx;
      tx         <= tx_nx;
      if (frame_done) byte_count <= byte_count + 8'd1;
    end
  end

endmodule
